bayer_bin2x2: RTL

- Parametrised 2x2 Bayer binning block in the camera image-processing path, between the sensor capture stage and the downstream RGB/gray consumers.
- Tracks pixel position internally, buffers one sensor line, and emits one output pixel per 2x2 Bayer quad.
- The output pixel is either gray (average of 4) or demosaiced RGB (R, averaged G, B).
- Bayer phase, data width and line length are parameters; the output mode is selectable at run time.

---
 rtl/bayer_bin2x2_if.sv | 29 ++
 rtl/bayer_bin2x2.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bayer_bin2x2_if.sv
// Pixel bus for the 2x2 Bayer binning block: raw sensor stream in, binned
// RGB/gray pixel stream out.
interface bayer_bin2x2_if #(
    parameter int DW = 12,
    parameter int XW = 11,
    parameter int YW = 11
);
    logic          iSOF;
    logic [DW-1:0] iDATA;
    logic          iDVAL;
    logic          iMODE;

    logic [DW-1:0] oRed;
    logic [DW-1:0] oGreen;
    logic [DW-1:0] oBlue;
    logic          oDVAL;
    logic [XW-2:0] oX;
    logic [YW-2:0] oY;

    modport master (
        output iSOF, iDATA, iDVAL, iMODE,
        input  oRed, oGreen, oBlue, oDVAL, oX, oY
    );

    modport slave (
        input  iSOF, iDATA, iDVAL, iMODE,
        output oRed, oGreen, oBlue, oDVAL, oX, oY
    );
endinterface

// File: rtl/bayer_bin2x2.sv
// 2x2 Bayer binning: buffers one even sensor row and emits one gray or
// demosaiced RGB pixel per quad through a two-stage pipeline.
module bayer_bin2x2 #(
    parameter int DW         = 12,
    parameter int LINE_WIDTH = 1280,
    parameter int BAYER      = 0,
    parameter int XW         = $clog2(LINE_WIDTH),
    parameter int YW         = 11
) (
    input  logic          iCLK,
    input  logic          iRST,
    bayer_bin2x2_if.slave pix
);

    localparam int HW = LINE_WIDTH / 2;
    localparam logic [XW-1:0] X_LAST = XW'(LINE_WIDTH - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic          sof_hit;
    logic          wr_en;
    logic          rd_en;
    logic          accept;
    logic [XW-2:0] bank_addr;

    // The line buffer is split into even/odd column banks so p00 and p01
    // come out of a single read address in the same cycle.
    logic [DW-1:0] mem_even [HW];
    logic [DW-1:0] mem_odd  [HW];
    logic [DW-1:0] rd_even_q;
    logic [DW-1:0] rd_odd_q;

    logic [DW-1:0] p10_q, p10_d;

    logic          s1_vld_q, s1_vld_d;
    logic [DW-1:0] s1_p00_q, s1_p00_d;
    logic [DW-1:0] s1_p01_q, s1_p01_d;
    logic [DW-1:0] s1_p10_q, s1_p10_d;
    logic [DW-1:0] s1_p11_q, s1_p11_d;
    logic          s1_mode_q, s1_mode_d;
    logic [XW-2:0] s1_x_q, s1_x_d;
    logic [YW-2:0] s1_y_q, s1_y_d;

    logic [DW+1:0] quad_sum;
    logic [DW:0]   g_sum;
    logic [DW-1:0] gray;
    logic [DW-1:0] red_c;
    logic [DW-1:0] green_c;
    logic [DW-1:0] blue_c;

    logic [DW-1:0] red_q, red_d;
    logic [DW-1:0] green_q, green_d;
    logic [DW-1:0] blue_q, blue_d;
    logic          dval_q, dval_d;
    logic [XW-2:0] ox_q, ox_d;
    logic [YW-2:0] oy_q, oy_d;

    // A valid start-of-frame pixel is itself position (0,0).
    always_comb begin
        sof_hit   = pix.iDVAL & pix.iSOF;
        cur_x     = sof_hit ? '0 : x_q;
        cur_y     = sof_hit ? '0 : y_q;
        wr_en     = pix.iDVAL & ~cur_y[0];
        rd_en     = pix.iDVAL & cur_y[0] & ~cur_x[0];
        accept    = pix.iDVAL & cur_y[0] & cur_x[0];
        bank_addr = cur_x[XW-1:1];

        x_d = x_q;
        y_d = y_q;
        if (pix.iDVAL) begin
            if (cur_x == X_LAST) begin
                x_d = '0;
                y_d = cur_y + 1'b1;
            end else begin
                x_d = cur_x + 1'b1;
                y_d = cur_y;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (wr_en & ~cur_x[0]) begin
            mem_even[bank_addr] <= pix.iDATA;
        end
        if (wr_en & cur_x[0]) begin
            mem_odd[bank_addr] <= pix.iDATA;
        end
        if (rd_en) begin
            rd_even_q <= mem_even[bank_addr];
            rd_odd_q  <= mem_odd[bank_addr];
        end
    end

    always_comb begin
        p10_d     = rd_en ? pix.iDATA : p10_q;

        s1_vld_d  = accept;
        s1_p00_d  = s1_p00_q;
        s1_p01_d  = s1_p01_q;
        s1_p10_d  = s1_p10_q;
        s1_p11_d  = s1_p11_q;
        s1_mode_d = s1_mode_q;
        s1_x_d    = s1_x_q;
        s1_y_d    = s1_y_q;
        if (accept) begin
            s1_p00_d  = rd_even_q;
            s1_p01_d  = rd_odd_q;
            s1_p10_d  = p10_q;
            s1_p11_d  = pix.iDATA;
            s1_mode_d = pix.iMODE;
            s1_x_d    = cur_x[XW-1:1];
            s1_y_d    = cur_y[YW-1:1];
        end
    end

    // Green always averages the two diagonal G sites of the quad; which
    // diagonal depends on the sensor phase.
    always_comb begin
        quad_sum = {2'b00, s1_p00_q} + {2'b00, s1_p01_q}
                 + {2'b00, s1_p10_q} + {2'b00, s1_p11_q};
        if (BAYER == 0 || BAYER == 3) begin
            g_sum = {1'b0, s1_p01_q} + {1'b0, s1_p10_q};
        end else begin
            g_sum = {1'b0, s1_p00_q} + {1'b0, s1_p11_q};
        end
        gray    = DW'(quad_sum >> 2);
        green_c = DW'(g_sum >> 1);
        case (BAYER)
            1: begin
                red_c  = s1_p01_q;
                blue_c = s1_p10_q;
            end
            2: begin
                red_c  = s1_p10_q;
                blue_c = s1_p01_q;
            end
            3: begin
                red_c  = s1_p11_q;
                blue_c = s1_p00_q;
            end
            default: begin
                red_c  = s1_p00_q;
                blue_c = s1_p11_q;
            end
        endcase
    end

    always_comb begin
        dval_d  = s1_vld_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        if (s1_vld_q) begin
            red_d   = s1_mode_q ? red_c   : gray;
            green_d = s1_mode_q ? green_c : gray;
            blue_d  = s1_mode_q ? blue_c  : gray;
            ox_d    = s1_x_q;
            oy_d    = s1_y_q;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            x_q       <= '0;
            y_q       <= '0;
            p10_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_p00_q  <= '0;
            s1_p01_q  <= '0;
            s1_p10_q  <= '0;
            s1_p11_q  <= '0;
            s1_mode_q <= 1'b0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
            dval_q    <= 1'b0;
            ox_q      <= '0;
            oy_q      <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            p10_q     <= p10_d;
            s1_vld_q  <= s1_vld_d;
            s1_p00_q  <= s1_p00_d;
            s1_p01_q  <= s1_p01_d;
            s1_p10_q  <= s1_p10_d;
            s1_p11_q  <= s1_p11_d;
            s1_mode_q <= s1_mode_d;
            s1_x_q    <= s1_x_d;
            s1_y_q    <= s1_y_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
            dval_q    <= dval_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
        end
    end

    assign pix.oRed   = red_q;
    assign pix.oGreen = green_q;
    assign pix.oBlue  = blue_q;
    assign pix.oDVAL  = dval_q;
    assign pix.oX     = ox_q;
    assign pix.oY     = oy_q;

endmodule
